// File: rtl/frame_line_writer.sv
// frame_line_writer: packs binarised pixel beats into BRAM lines of the ping-pong frame buffer
module frame_line_writer #(
    parameter int BRAM_DATA_W  = 128,
    parameter int PIX_W        = 8,
    parameter int LINES        = 64,
    parameter int BRAM_ADDR_W  = 8,
    parameter int FRAME_OFFSET = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_sof,
    input  logic                   pix_eol,
    input  logic                   corr_idle,
    output logic                   bram_we,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    output logic [BRAM_DATA_W-1:0] bram_wdata,
    output logic                   curr_frame_bram_offset_sel,
    output logic                   frame_ready,
    output logic                   line_err
);
    localparam int BEATS = BRAM_DATA_W / PIX_W;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int LW    = LINES > 1 ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {IDLE, PACK, WRITE, SWAP} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt;
    logic [LW-1:0]          line;
    logic [BRAM_DATA_W-1:0] pack;
    logic [BRAM_DATA_W-1:0] first_beat;
    logic [BRAM_DATA_W-1:0] placed;
    logic                   accept;
    logic                   last_beat;
    logic                   last_line;
    logic                   wr_sel;

    assign accept     = pix_valid & pix_ready;
    assign last_beat  = cnt == CW'(BEATS - 1);
    assign last_line  = line == LW'(LINES - 1);
    assign wr_sel     = ~curr_frame_bram_offset_sel;
    assign first_beat = {pix_data, {(BRAM_DATA_W - PIX_W){1'b0}}};
    assign placed     = first_beat >> (int'(cnt) * PIX_W);

    // state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // next-state: sof opens a frame, a full or eol-terminated line writes, last line waits to swap
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (accept && pix_sof) ? PACK : IDLE;
            PACK:    state_next = (accept && !pix_sof && (last_beat || pix_eol)) ? WRITE : PACK;
            WRITE:   state_next = last_line ? SWAP : PACK;
            SWAP:    state_next = corr_idle ? IDLE : SWAP;
            default: state_next = IDLE;
        endcase
    end

    // input handshake: idle only listens while the correlator is not running
    always_comb begin
        pix_ready = state == IDLE ? corr_idle : state == PACK;
    end

    // datapath: beat packing, registered BRAM write port, buffer swap and error flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt                        <= '0;
            line                       <= '0;
            pack                       <= '0;
            bram_we                    <= 1'b0;
            bram_addr                  <= '0;
            bram_wdata                 <= '0;
            curr_frame_bram_offset_sel <= 1'b0;
            frame_ready                <= 1'b0;
            line_err                   <= 1'b0;
        end else begin
            bram_we     <= 1'b0;
            frame_ready <= 1'b0;
            case (state)
                IDLE: if (accept && pix_sof) begin
                    pack <= first_beat;
                    cnt  <= CW'(1);
                    line <= '0;
                end
                PACK: if (accept) begin
                    if (pix_sof) begin
                        line_err <= 1'b1;
                        pack     <= first_beat;
                        cnt      <= CW'(1);
                        line     <= '0;
                    end else if (last_beat || pix_eol) begin
                        bram_we    <= 1'b1;
                        bram_wdata <= pack | placed;
                        bram_addr  <= BRAM_ADDR_W'(line) + (wr_sel ? BRAM_ADDR_W'(FRAME_OFFSET) : '0);
                        pack       <= '0;
                        cnt        <= '0;
                        if (!(last_beat && pix_eol)) line_err <= 1'b1;
                    end else begin
                        pack <= pack | placed;
                        cnt  <= cnt + CW'(1);
                    end
                end
                WRITE: line <= last_line ? '0 : line + LW'(1);
                SWAP: if (corr_idle) begin
                    curr_frame_bram_offset_sel <= wr_sel;
                    frame_ready                <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_line_writer.sv
// tb_frame_line_writer: table vectors, directed frame sequences and random data against a line-level model
module tb_frame_line_writer;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [7:0]   pix_data = '0;
    logic         pix_sof = 1'b0;
    logic         pix_eol = 1'b0;
    logic         corr_idle = 1'b1;
    logic         bram_we;
    logic [7:0]   bram_addr;
    logic [127:0] bram_wdata;
    logic         sel;
    logic         frame_ready;
    logic         line_err;

    frame_line_writer dut (
        .clk(clk), .resetn(resetn), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .corr_idle(corr_idle),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .curr_frame_bram_offset_sel(sel), .frame_ready(frame_ready), .line_err(line_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [127:0] d; } wr_t;
    typedef struct { int n; bit eol; logic [127:0] wdata; bit err; } vec_t;

    wr_t          exp_q[$];
    vec_t         tbl[5];
    int           n_cmp = 0;
    int           n_err = 0;
    int           fr_cnt = 0;
    logic         m_sel = 1'b0;
    logic [127:0] mem[256];
    logic [127:0] snap[64];

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // write monitor: every BRAM write must match the next expected line
    always @(negedge clk) begin
        if (frame_ready) fr_cnt++;
        if (bram_we) begin
            mem[bram_addr] = bram_wdata;
            check("ready_in_write", 128'(pix_ready), 128'(0));
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write addr=%0d data=%h", bram_addr, bram_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 128'(bram_addr), 128'(e.a));
                check("wr_data", bram_wdata, e.d);
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        int n;
        n = 0;
        pix_valid = 1'b1; pix_data = d; pix_sof = s; pix_eol = e;
        while (!pix_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 128'(pix_ready), 128'(1));
        @(negedge clk);
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    // mode 0: line^beat, 1: random, 2: beat+1
    task automatic send_line(input int l, input int n, input bit sof, input int mode,
                             input int gap, input bit eol_last, input bit push);
        logic [7:0]   b[16];
        logic [127:0] d;
        wr_t          e;
        d = '0;
        for (int k = 0; k < n; k++) begin
            b[k] = mode == 0 ? 8'(l ^ k) : mode == 1 ? 8'($urandom) : 8'(k + 1);
            d[127 - 8 * k -: 8] = b[k];
        end
        if (push) begin
            e.a = 8'(l + (m_sel ? 0 : 64));
            e.d = d;
            exp_q.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            while (gap > 0 && int'($urandom_range(0, 99)) < gap) @(negedge clk);
            beat(b[k], sof && k == 0, eol_last && k == n - 1);
        end
    endtask

    task automatic send_frame(input int mode, input int gap, input int short_l, input int short_n);
        for (int l = 0; l < 64; l++) send_line(l, l == short_l ? short_n : 16, l == 0, mode, gap, 1'b1, 1'b1);
    endtask

    task automatic wait_frame();
        int f0;
        int n;
        f0 = fr_cnt;
        n = 0;
        while (fr_cnt == f0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        m_sel = ~m_sel;
        check("frame_ready_pulses", 128'(fr_cnt - f0), 128'(1));
        check("sel", 128'(sel), 128'(m_sel));
        check("writes_pending", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
        resetn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("we_in_reset", 128'(bram_we), 128'(0));
        end
        resetn = 1'b1;
        exp_q.delete();
        m_sel = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_we", 128'(bram_we), 128'(0));
        check("rst_addr", 128'(bram_addr), 128'(0));
        check("rst_wdata", bram_wdata, 128'(0));
        check("rst_frame_ready", 128'(frame_ready), 128'(0));
        check("rst_sel", 128'(sel), 128'(0));
        check("rst_line_err", 128'(line_err), 128'(0));
        check("rst_ready_idle", 128'(pix_ready), 128'(1));
    endtask

    initial begin
        tbl[0] = '{16, 1'b1, 128'h0102030405060708_090a0b0c0d0e0f10, 1'b0};
        tbl[1] = '{16, 1'b0, 128'h0102030405060708_090a0b0c0d0e0f10, 1'b1};
        tbl[2] = '{6,  1'b1, 128'h0102030405060000_0000000000000000, 1'b1};
        tbl[3] = '{1,  1'b1, 128'h0100000000000000_0000000000000000, 1'b1};
        tbl[4] = '{15, 1'b1, 128'h0102030405060708_090a0b0c0d0e0f00, 1'b1};

        do_reset();
        check_reset_outputs();

        foreach (tbl[i]) begin
            wr_t e;
            do_reset();
            send_line(0, 16, 1'b1, 2, 0, 1'b1, 1'b1);
            e.a = 8'd65;
            e.d = tbl[i].wdata;
            exp_q.push_back(e);
            send_line(1, tbl[i].n, 1'b0, 2, 0, tbl[i].eol, 1'b0);
            repeat (3) @(negedge clk);
            check($sformatf("tbl%0d_line_err", i), 128'(line_err), 128'(tbl[i].err));
            check($sformatf("tbl%0d_written", i), 128'(exp_q.size()), 128'(0));
        end

        beat(8'hAA, 1'b1, 1'b0);
        repeat (4) beat(8'h55, 1'b0, 1'b0);
        do_reset();
        check_reset_outputs();

        send_frame(0, 0, -1, 16);
        wait_frame();
        check("line0_msb", 128'(mem[64][127:120]), 128'(0));
        for (int l = 0; l < 64; l++) snap[l] = mem[64 + l];

        send_frame(1, 0, -1, 16);
        wait_frame();

        for (int l = 0; l < 63; l++) send_line(l, 16, l == 0, 1, 0, 1'b1, 1'b1);
        corr_idle = 1'b0;
        send_line(63, 16, 1'b0, 1, 0, 1'b1, 1'b1);
        repeat (10) begin
            check("bp_ready", 128'(pix_ready), 128'(0));
            check("bp_frame_ready", 128'(frame_ready), 128'(0));
            @(negedge clk);
        end
        corr_idle = 1'b1;
        wait_frame();

        send_frame(0, 50, -1, 16);
        wait_frame();
        for (int l = 0; l < 64; l++) check($sformatf("gap_line%0d", l), mem[l], snap[l]);

        do_reset();
        send_frame(0, 0, 3, 6);
        wait_frame();
        check("short_err", 128'(line_err), 128'(1));
        check("short_pad", 128'(mem[67][79:0]), 128'(0));
        check("short_upper", 128'(mem[67][127:80]), 128'(48'h030201000706));

        do_reset();
        for (int l = 0; l < 10; l++) send_line(l, 16, l == 0, 1, 0, 1'b1, 1'b1);
        check("pre_sof_err", 128'(line_err), 128'(0));
        send_frame(1, 30, -1, 16);
        wait_frame();
        check("mid_sof_err", 128'(line_err), 128'(1));

        check("final_pending", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
